// File: rtl/paced_counter.sv
// Purpose : programmable rate divider stepping a modulo-(COUNT_MAX+1) up/down counter.
// Latency : Tick/CounterValue update on the step edge itself (registered, visible the next cycle).
// Backpressure: none; free-running, Pause freezes the divider and the counter in place.
//
// Ports:
//   ClockIn      - clock, all logic on posedge
//   Reset        - synchronous, active-high
//   Speed        - rate select: 0 -> P=1, 1 -> P=CF, 2 -> P=2*CF, 3 -> P=4*CF
//   Dir          - 1 = count up, 0 = count down (sampled on the step edge)
//   Pause        - holds divider and counter, suppresses Tick/Wrap
//   Load         - single-cycle request: load min(LoadValue, COUNT_MAX), restart period
//   LoadValue    - value for Load
//   Tick         - high for the cycle after each step edge
//   CounterValue - registered count
//   Wrap         - wrap pulse coincident with Tick (only with PACED_COUNTER_WRAP_EN)
module paced_counter #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int COUNT_WIDTH     = 4,
    parameter int COUNT_MAX       = 15
) (
    input  logic                   ClockIn,
    input  logic                   Reset,
    input  logic [1:0]             Speed,
    input  logic                   Dir,
    input  logic                   Pause,
    input  logic                   Load,
    input  logic [COUNT_WIDTH-1:0] LoadValue,
    output logic                   Tick,
    output logic [COUNT_WIDTH-1:0] CounterValue
`ifdef PACED_COUNTER_WRAP_EN
    ,
    output logic                   Wrap
`endif
);

    localparam int QW = $clog2(4 * CLOCK_FREQUENCY) + 1;
    localparam logic [COUNT_WIDTH-1:0] CMAX = COUNT_WIDTH'(COUNT_MAX);
    localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);

    // Reload value for the divider: period length minus one for the given speed.
    function automatic logic [QW-1:0] period_m1(input logic [1:0] s);
        case (s)
            2'd0:    return '0;
            2'd1:    return QW'(CLOCK_FREQUENCY - 1);
            2'd2:    return QW'(2 * CLOCK_FREQUENCY - 1);
            default: return QW'(4 * CLOCK_FREQUENCY - 1);
        endcase
    endfunction

    logic [QW-1:0]          q_cnt;
    logic [1:0]             active_speed;
    logic [COUNT_WIDTH-1:0] step_val;
    logic                   step_wraps;
    logic [COUNT_WIDTH-1:0] load_val;

    // Next counter value for a step, with wrap detection at either end.
    always_comb begin
        step_wraps = 1'b0;
        step_val   = CounterValue;
        if (Dir) begin
            step_wraps = (CounterValue == CMAX);
            step_val   = step_wraps ? '0 : CounterValue + ONE;
        end else begin
            step_wraps = (CounterValue == '0);
            step_val   = step_wraps ? CMAX : CounterValue - ONE;
        end
    end

    // Out-of-range load values clamp to the modulus so no value above COUNT_MAX appears.
    assign load_val = (LoadValue > CMAX) ? CMAX : LoadValue;

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            q_cnt        <= period_m1(Speed);
            active_speed <= Speed;
            CounterValue <= '0;
            Tick         <= 1'b0;
        end else if (Load) begin
            q_cnt        <= period_m1(Speed);
            active_speed <= Speed;
            CounterValue <= load_val;
            Tick         <= 1'b0;
        end else if (Pause) begin
            Tick         <= 1'b0;
        end else if (q_cnt != '0) begin
            q_cnt        <= q_cnt - QW'(1);
            Tick         <= 1'b0;
        end else begin
            // Period boundary: the only place a new Speed is adopted, so a
            // mid-period change never alters the period already running.
            q_cnt        <= period_m1(Speed);
            active_speed <= Speed;
            CounterValue <= step_val;
            Tick         <= 1'b1;
        end
    end

`ifdef PACED_COUNTER_WRAP_EN
    always_ff @(posedge ClockIn) begin
        if (Reset || Load || Pause)
            Wrap <= 1'b0;
        else
            Wrap <= (q_cnt == '0) && step_wraps;
    end
`endif

    // The divider never runs beyond the period of the speed currently in force.
    property p_q_in_range;
        @(posedge ClockIn) disable iff (Reset) q_cnt <= period_m1(active_speed);
    endproperty
    a_q_in_range: assert property (p_q_in_range);

endmodule

// File: tb/tb_paced_counter.sv
// Purpose : scoreboard bench for paced_counter (CLOCK_FREQUENCY=4, COUNT_MAX=9).
// Latency : expected steps are queued with their absolute edge number.
// Backpressure: none; a negedge monitor pops an entry whenever Tick is high.
module tb_paced_counter;

    logic       ClockIn   = 1'b0;
    logic       Reset     = 1'b1;
    logic [1:0] Speed     = 2'd0;
    logic       Dir       = 1'b1;
    logic       Pause     = 1'b0;
    logic       Load      = 1'b0;
    logic [3:0] LoadValue = 4'd0;
    logic       Tick;
    logic [3:0] CounterValue;
`ifdef PACED_COUNTER_WRAP_EN
    logic       Wrap;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    paced_counter #(
        .CLOCK_FREQUENCY(4),
        .COUNT_WIDTH    (4),
        .COUNT_MAX      (9)
    ) dut (
        .ClockIn     (ClockIn),
        .Reset       (Reset),
        .Speed       (Speed),
        .Dir         (Dir),
        .Pause       (Pause),
        .Load        (Load),
        .LoadValue   (LoadValue),
        .Tick        (Tick),
        .CounterValue(CounterValue)
`ifdef PACED_COUNTER_WRAP_EN
        ,
        .Wrap        (Wrap)
`endif
    );

    always #5 ClockIn = ~ClockIn;

    // Number of rising edges seen so far; read on the falling edge.
    always @(posedge ClockIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int v, input logic w);
        exp_t x;
        x.cyc  = c;
        x.val  = 4'(v);
        x.wrap = w;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge ClockIn);
    endtask

    // Apply one reset edge with the given speed, check the cleared state,
    // release, and record the edge count from which steps are timed.
    task automatic do_reset(input logic [1:0] s);
        Reset = 1'b1;
        Speed = s;
        @(negedge ClockIn);
        check("reset_count", CounterValue, 0);
        check("reset_tick", Tick, 0);
`ifdef PACED_COUNTER_WRAP_EN
        check("reset_wrap", Wrap, 0);
`endif
        Reset = 1'b0;
        base  = cyc;
    endtask

    // Monitor: every Tick consumes one scoreboard entry; entries whose edge
    // has passed without a Tick are reported as missed.
    always @(negedge ClockIn) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_tick: no tick at edge %0d expected value %0d", sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end
        if (Tick === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick: tick at edge %0d value %0d, none expected", cyc, CounterValue);
            end else begin
                e = sb.pop_front();
                check("tick_edge", cyc, e.cyc);
                check("tick_value", CounterValue, e.val);
`ifdef PACED_COUNTER_WRAP_EN
                check("tick_wrap", Wrap, e.wrap);
`endif
            end
        end
`ifdef PACED_COUNTER_WRAP_EN
        else if (!Reset) begin
            check("wrap_idle", Wrap, 0);
        end
`endif
    end

    initial begin
        repeat (2) @(negedge ClockIn);

        // Speed 0 counting up: 1..9,0,1 on consecutive edges.
        Dir = 1'b1;
        do_reset(2'd0);
        for (int k = 1; k <= 11; k++) push(base + k, k % 10, k == 10);
        wait_until(base + 11);

        // Speed 2 (P=8): first step on the 8th edge, then every 8.
        do_reset(2'd2);
        push(base + 8, 1, 1'b0);
        push(base + 16, 2, 1'b0);
        push(base + 24, 3, 1'b0);
        wait_until(base + 12);
        check("mid_period_hold", CounterValue, 1);
        wait_until(base + 26);

        // Speed 1 -> 3 two cycles into a period: that period still lasts 4, next lasts 16.
        do_reset(2'd1);
        push(base + 4, 1, 1'b0);
        push(base + 8, 2, 1'b0);
        push(base + 12, 3, 1'b0);
        push(base + 28, 4, 1'b0);
        wait_until(base + 10);
        Speed = 2'd3;
        wait_until(base + 30);

        // Load 3, count down at speed 0: 2,1,0,9,8 with wrap on 0->9; LoadValue 12 clamps to 9.
        Dir = 1'b0;
        do_reset(2'd0);
        Load      = 1'b1;
        LoadValue = 4'd3;
        wait_until(base + 1);
        check("load_value", CounterValue, 3);
        check("load_tick", Tick, 0);
        Load = 1'b0;
        push(base + 2, 2, 1'b0);
        push(base + 3, 1, 1'b0);
        push(base + 4, 0, 1'b0);
        push(base + 5, 9, 1'b1);
        push(base + 6, 8, 1'b0);
        wait_until(base + 6);
        Load      = 1'b1;
        LoadValue = 4'd12;
        wait_until(base + 7);
        check("load_clamp", CounterValue, 9);
        Load = 1'b0;
        push(base + 8, 8, 1'b0);
        wait_until(base + 8);
        Dir = 1'b1;
        push(base + 9, 9, 1'b0);
        push(base + 10, 0, 1'b1);
        push(base + 11, 1, 1'b0);
        wait_until(base + 11);

        // Pause 5 cycles mid-period at speed 1: step arrives 5 edges late.
        do_reset(2'd1);
        push(base + 4, 1, 1'b0);
        wait_until(base + 5);
        Pause = 1'b1;
        wait_until(base + 8);
        check("pause_hold", CounterValue, 1);
        wait_until(base + 10);
        Pause = 1'b0;
        push(base + 13, 2, 1'b0);
        // Load while paused still updates the counter and restarts the period.
        wait_until(base + 14);
        Pause = 1'b1;
        wait_until(base + 16);
        Load      = 1'b1;
        LoadValue = 4'd7;
        wait_until(base + 17);
        check("load_in_pause", CounterValue, 7);
        Load = 1'b0;
        wait_until(base + 18);
        Pause = 1'b0;
        push(base + 22, 8, 1'b0);
        push(base + 26, 9, 1'b0);
        wait_until(base + 26);

        // Reset mid-count while Tick is high, then full period at speed 1.
        do_reset(2'd0);
        for (int k = 1; k <= 7; k++) push(base + k, k, 1'b0);
        wait_until(base + 7);
        check("pre_reset_count", CounterValue, 7);
        do_reset(2'd1);
        push(base + 4, 1, 1'b0);
        wait_until(base + 6);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
